// File: rtl/apb_arb_pkg.sv
// ============================================================================
// apb_arb_pkg : shared types, defaults and helpers for apb_req_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_arb_pkg;

    localparam int c_NUM_REQ_DEF = 4;
    localparam int c_ADDR_W_DEF  = 32;
    localparam int c_DATA_W_DEF  = 32;
    localparam int c_MAX_REQ     = 8;
    localparam int c_MAX_IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2
    } apb_st_e;

    function automatic logic [c_MAX_REQ-1:0] onehot(input logic [c_MAX_IDX_W-1:0] idx);
        logic [c_MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, search starts at i_ptr and wraps
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(c_NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_req
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_winner  = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!o_any_req && i_req[w_idx]) begin
                o_winner  = w_idx;
                o_any_req = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_req_arbiter.sv
// ============================================================================
// apb_req_arbiter : round-robin APB master sharing one completer among NUM_REQ
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ_DEF,
    parameter int ADDR_W  = c_ADDR_W_DEF,
    parameter int DATA_W  = c_DATA_W_DEF
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    apb_st_e             state_q, state_d;
    logic [c_IDX_W-1:0]  grant_q, grant_d;
    logic [c_IDX_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;

    logic [NUM_REQ-1:0]  w_grant_oh;
    logic [NUM_REQ-1:0]  w_arb_req;
    logic                w_arb_edge;
    logic [c_IDX_W-1:0]  w_win;
    logic                w_any;

    assign w_grant_oh = NUM_REQ'(onehot(c_MAX_IDX_W'(grant_q)));

    // At the edge closing ENABLE the served requester is masked and the
    // pointer already moves past it, so the search starts at grant+1.
    always_comb begin
        ptr_d      = ptr_q;
        w_arb_req  = req;
        w_arb_edge = 1'b0;
        case (state_q)
            IDLE: begin
                w_arb_edge = 1'b1;
            end
            ENABLE: begin
                w_arb_edge = 1'b1;
                w_arb_req  = req & ~w_grant_oh;
                ptr_d      = (grant_q == c_IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            default: ;
        endcase
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .i_req     (w_arb_req),
        .i_ptr     (ptr_d),
        .o_winner  (w_win),
        .o_any_req (w_any)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_any) state_d = SETUP;
            SETUP:   state_d = ENABLE;
            ENABLE:  state_d = w_any ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel      = (state_q != IDLE);
        penable   = (state_q == ENABLE);
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == ENABLE) ? w_grant_oh : '0;
        rsp_rdata = ((state_q == ENABLE) && !pwrite_q) ? prdata : '0;
    end

    always_comb begin
        grant_d  = grant_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        if (w_arb_edge && w_any) begin
            grant_d  = w_win;
            paddr_d  = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
            pwrite_d = req_write[w_win];
            pwdata_d = req_wdata[int'(w_win)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            grant_q  <= '0;
            ptr_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end

    assign paddr  = paddr_q;
    assign pwrite = pwrite_q;
    assign pwdata = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
// ============================================================================
// tb_apb_req_arbiter : randomized and directed checks of apb_req_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] rdata;
    } ack_t;

    logic            pclk = 1'b0;
    logic            preset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            busy;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata)
    );

    always #5 pclk = ~pclk;

    // 16x32 register-file completer: read data registered in SETUP, write at ENABLE.
    logic [31:0] cmem [16];
    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            prdata <= '0;
            for (int i = 0; i < 16; i++) cmem[i] <= '0;
        end else begin
            if (psel && !penable && !pwrite) prdata <= cmem[paddr[5:2]];
            if (psel && penable && pwrite) cmem[paddr[5:2]] <= pwdata;
        end
    end

    // Requester command queues, transaction-level model state and observation log.
    cmd_t         rq [N][$];
    logic [N-1:0] pulse_mask = '0;
    int           cyc = 0;
    bit           m_xfer = 0;
    int           m_en_cyc = 0;
    int           m_grant = 0;
    int           m_ptr = 0;
    cmd_t         m_cmd = '0;
    logic [31:0]  shadow [16];
    ack_t         log_q [$];
    int           psel_cnt = 0;
    int           n_cmp = 0;
    int           n_fail = 0;

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.wr   = 1'($urandom_range(0, 1));
        c.addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        c.data = $urandom();
        return c;
    endfunction

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) p = 1;
        return p;
    endfunction

    // One negedge: compare outputs with the model, then drive the next inputs
    // and let the model decide what the coming edge grants.
    task automatic step_body();
        logic [N-1:0] exp_v;
        logic         exp_sel;
        logic         exp_en;
        logic [31:0]  exp_rd;
        logic [N-1:0] cand;
        cmd_t         c;
        ack_t         a;
        int           w;
        exp_sel = m_xfer;
        exp_en  = m_xfer && (cyc == m_en_cyc);
        exp_v   = '0;
        if (exp_en) exp_v[m_grant] = 1'b1;
        exp_rd  = (exp_en && !m_cmd.wr) ? shadow[m_cmd.addr[5:2]] : 32'd0;
        if (psel) psel_cnt++;
        if (rsp_valid != '0) begin
            a.cyc = cyc; a.idx = -1; a.rdata = rsp_rdata;
            for (int i = N - 1; i >= 0; i--) if (rsp_valid[i]) a.idx = i;
            log_q.push_back(a);
        end
        n_cmp++;
        if ({psel, penable, busy, rsp_valid} !== {exp_sel, exp_en, exp_sel, exp_v}) begin
            n_fail++;
            $display("FAIL ctrl cyc=%0d psel/pen/busy/vld got %b%b%b/%b required %b%b%b/%b",
                     cyc, psel, penable, busy, rsp_valid, exp_sel, exp_en, exp_sel, exp_v);
        end
        n_cmp++;
        if (rsp_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL rdata cyc=%0d got %h required %h", cyc, rsp_rdata, exp_rd);
        end
        if (exp_en) begin
            n_cmp++;
            if ({paddr, pwrite, pwdata} !== {m_cmd.addr, m_cmd.wr, m_cmd.data}) begin
                n_fail++;
                $display("FAIL cmd cyc=%0d got a=%h w=%b d=%h required a=%h w=%b d=%h",
                         cyc, paddr, pwrite, pwdata, m_cmd.addr, m_cmd.wr, m_cmd.data);
            end
            if (m_cmd.wr) shadow[m_cmd.addr[5:2]] = m_cmd.data;
            if (rq[m_grant].size() > 0) void'(rq[m_grant].pop_front());
        end
        for (int i = 0; i < N; i++) begin
            c = (rq[i].size() > 0) ? rq[i][0] : rand_cmd();
            req[i]                = (rq[i].size() > 0) || pulse_mask[i];
            req_write[i]          = c.wr;
            req_addr[i*AW +: AW]  = c.addr;
            req_wdata[i*DW +: DW] = c.data;
        end
        if (!m_xfer || exp_en) begin
            cand = req;
            if (exp_en) begin
                m_ptr = (m_grant + 1) % N;
                cand[m_grant] = 1'b0;
            end
            m_xfer = 0;
            for (int k = 0; k < N; k++) begin
                w = (m_ptr + k) % N;
                if (!m_xfer && cand[w]) begin
                    m_xfer   = 1;
                    m_grant  = w;
                    m_en_cyc = cyc + 2;
                    m_cmd    = '{req_write[w], req_addr[w*AW +: AW], req_wdata[w*DW +: DW]};
                end
            end
        end
    endtask

    task automatic step();
        @(negedge pclk);
        cyc++;
        step_body();
    endtask

    task automatic run_until_idle(input int max);
        int k = 0;
        while ((m_xfer || pending()) && k < max) begin
            step();
            k++;
        end
        n_cmp++;
        if (k >= max) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d cycles required < %0d", k, max);
        end
    endtask

    task automatic hit_reset();
        preset = 1'b1;
        #1;
        n_cmp++;
        if ({psel, penable, pwrite, busy, rsp_valid, paddr, pwdata, rsp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got sel=%b en=%b wr=%b busy=%b vld=%b a=%h d=%h rd=%h required all 0",
                     psel, penable, pwrite, busy, rsp_valid, paddr, pwdata, rsp_rdata);
        end
        @(negedge pclk);
        cyc++;
        m_xfer = 0;
        m_ptr  = 0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        @(negedge pclk);
        cyc++;
        preset = 1'b0;
        step_body();
    endtask

    task automatic test_reset();
        hit_reset();
        for (int i = 0; i < 3; i++) rq[i].push_back(rand_cmd());
        repeat (5) step();
        #1;
        hit_reset();
        run_until_idle(100);
    endtask

    task automatic test_all_four();
        int base;
        int p0;
        #1;
        hit_reset();
        base = log_q.size();
        p0   = psel_cnt;
        for (int i = 0; i < N; i++) rq[i].push_back('{1'b1, 32'(i * 4), $urandom()});
        run_until_idle(50);
        n_cmp++;
        if (log_q.size() - base != 4) begin
            n_fail++;
            $display("FAIL all4_count got %0d required 4", log_q.size() - base);
        end
        for (int i = 0; i < 4 && base + i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[base+i].idx != i || log_q[base+i].cyc != log_q[base].cyc + 2 * i) begin
                n_fail++;
                $display("FAIL all4_order[%0d] got req=%0d cyc=%0d required req=%0d cyc=%0d",
                         i, log_q[base+i].idx, log_q[base+i].cyc, i, log_q[base].cyc + 2 * i);
            end
        end
        n_cmp++;
        if (psel_cnt - p0 != 8) begin
            n_fail++;
            $display("FAIL all4_psel_cycles got %0d required 8", psel_cnt - p0);
        end
    endtask

    task automatic test_alternating();
        int base;
        base = log_q.size();
        for (int i = 0; i < 3; i++) begin
            rq[0].push_back(rand_cmd());
            rq[2].push_back(rand_cmd());
        end
        run_until_idle(100);
        n_cmp++;
        if (log_q.size() - base != 6) begin
            n_fail++;
            $display("FAIL alt_count got %0d required 6", log_q.size() - base);
        end
        for (int i = 0; i < 6 && base + i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[base+i].idx != ((i % 2 == 0) ? 0 : 2)) begin
                n_fail++;
                $display("FAIL alt_order[%0d] got %0d required %0d",
                         i, log_q[base+i].idx, (i % 2 == 0) ? 0 : 2);
            end
        end
        base = log_q.size();
        rq[0].push_back(rand_cmd());
        run_until_idle(50);
        repeat (3) step();
        n_cmp++;
        if (log_q.size() - base != 1 || (log_q.size() > base && log_q[base].idx != 0)) begin
            n_fail++;
            $display("FAIL single_no_dup got %0d acks required 1 ack from req 0", log_q.size() - base);
        end
    endtask

    task automatic test_write_read();
        int base;
        int drv;
        base = log_q.size();
        drv  = cyc + 1;
        rq[0].push_back('{1'b1, 32'h4, 32'hDEADBEEF});
        rq[0].push_back('{1'b0, 32'h4, 32'h0});
        run_until_idle(50);
        n_cmp++;
        if (log_q.size() - base != 2) begin
            n_fail++;
            $display("FAIL wr_rd_count got %0d required 2", log_q.size() - base);
        end else begin
            n_cmp++;
            if (log_q[base].idx != 0 || log_q[base].cyc != drv + 2) begin
                n_fail++;
                $display("FAIL wr_latency got req=%0d cyc=%0d required req=0 cyc=%0d",
                         log_q[base].idx, log_q[base].cyc, drv + 2);
            end
            n_cmp++;
            if (log_q[base+1].rdata !== 32'hDEADBEEF || log_q[base+1].cyc != log_q[base].cyc + 3) begin
                n_fail++;
                $display("FAIL rd_data got %h at cyc %0d required DEADBEEF at cyc %0d",
                         log_q[base+1].rdata, log_q[base+1].cyc, log_q[base].cyc + 3);
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, N - 1);
                if (rq[r].size() < 3) rq[r].push_back(rand_cmd());
            end
            step();
        end
        run_until_idle(300);
    endtask

    task automatic test_reset_enable();
        int base;
        int k = 0;
        rq[2].push_back('{1'b1, 32'h8, 32'h1234});
        while (!m_xfer && k < 20) begin
            step();
            k++;
        end
        n_cmp++;
        if (!m_xfer || m_grant != 2) begin
            n_fail++;
            $display("FAIL rst_en_setup got xfer=%0d grant=%0d required 1/2", m_xfer, m_grant);
        end
        rq[0].push_back(rand_cmd());
        rq[3].push_back(rand_cmd());
        step();
        base = log_q.size();
        @(posedge pclk);
        #2;
        hit_reset();
        run_until_idle(100);
        n_cmp++;
        if (log_q.size() - base != 3 || (log_q.size() > base && log_q[base].idx != 0)) begin
            n_fail++;
            $display("FAIL rst_en_next got %0d acks first=%0d required 3 acks first=0",
                     log_q.size() - base, (log_q.size() > base) ? log_q[base].idx : -1);
        end
        base = log_q.size();
        rq[1].push_back('{1'b0, 32'h8, 32'h0});
        run_until_idle(50);
        n_cmp++;
        if (log_q.size() <= base || log_q[base].rdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL rst_en_reissue got %h required 00001234",
                     (log_q.size() > base) ? log_q[base].rdata : 32'hx);
        end
    endtask

    task automatic test_pulse();
        int base;
        int hits = 0;
        base = log_q.size();
        rq[0].push_back(rand_cmd());
        rq[0].push_back(rand_cmd());
        step();
        n_cmp++;
        if (!(m_xfer && cyc + 2 == m_en_cyc)) begin
            n_fail++;
            $display("FAIL pulse_setup got xfer=%0d required 1", m_xfer);
        end
        pulse_mask = 4'b0010;
        step();
        pulse_mask = '0;
        run_until_idle(50);
        for (int i = base; i < log_q.size(); i++) if (log_q[i].idx == 1) hits++;
        n_cmp++;
        if (hits != 0 || log_q.size() - base != 2) begin
            n_fail++;
            $display("FAIL pulse_ignored got req1_acks=%0d total=%0d required 0/2", hits, log_q.size() - base);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        #2;
        test_reset();
        test_all_four();
        test_alternating();
        test_write_read();
        test_random();
        test_reset_enable();
        test_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
